// File: rtl/fprint_master_arbiter_pkg.sv
// Shared definitions for the fingerprint-unit master arbiter: FSM encodings and default widths.
package fprint_master_arbiter_pkg;

    typedef enum logic [0:0] {
        ARB_STATE_IDLE = 1'b0,
        ARB_STATE_BUSY = 1'b1
    } arb_state_e;

    localparam int ARB_ADDR_WIDTH_DEF = 32;
    localparam int ARB_DATA_WIDTH_DEF = 32;
    localparam int ARB_TIMEOUT_DEF    = 1024;

    // Index width for a core number; at least one bit so a 1-entry range stays legal.
    function automatic int arb_idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fprint_master_arbiter_rr_picker.sv
// Combinational round-robin priority encoder: first requester after last_i, wrapping modulo NUM_CORES.
module fprint_rr_picker
    import fprint_master_arbiter_pkg::*;
#(
    parameter int NUM_CORES = 2,
    parameter int IDX_W     = arb_idx_width(NUM_CORES)
) (
    input  logic [NUM_CORES-1:0] req_i,
    input  logic [IDX_W-1:0]     last_i,
    output logic [IDX_W-1:0]     idx_o,
    output logic                 valid_o
);

    logic [IDX_W-1:0] cand;

    // Scan from lowest priority (last itself) to highest (last+1) so the final hit wins.
    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = '0;
        for (int k = NUM_CORES; k >= 1; k--) begin
            cand = IDX_W'((int'(last_i) + k) % NUM_CORES);
            if (req_i[cand]) begin
                idx_o   = cand;
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fprint_master_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM master port among NUM_CORES fingerprint units.
// Optional watchdog enabled by defining FPRINT_ARB_TIMEOUT_EN.
module fprint_master_arbiter
    import fprint_master_arbiter_pkg::*;
#(
    parameter int NUM_CORES  = 2,
    parameter int ADDR_WIDTH = ARB_ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = ARB_DATA_WIDTH_DEF,
    parameter int TIMEOUT    = ARB_TIMEOUT_DEF
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_CORES*ADDR_WIDTH-1:0] req_address,
    input  logic [NUM_CORES-1:0]           req_write,
    input  logic [NUM_CORES-1:0]           req_read,
    input  logic [NUM_CORES*DATA_WIDTH-1:0] req_writedata,
    output logic [NUM_CORES-1:0]           req_waitrequest,
    output logic [DATA_WIDTH-1:0]          req_readdata,
    output logic [ADDR_WIDTH-1:0]          master_address,
    output logic                           master_write,
    output logic                           master_read,
    output logic [DATA_WIDTH-1:0]          master_writedata,
    input  logic                           master_waitrequest,
    input  logic [DATA_WIDTH-1:0]          master_readdata,
    output logic                           arb_error,
    output arb_state_e                     dbg_state_o
);

    localparam int IW = arb_idx_width(NUM_CORES);

    // Handshake: a core's transfer completes on the rising edge where it drives write/read
    // and sees req_waitrequest low; it must hold its signals while waitrequest is high.

    arb_state_e      state_q, state_d;
    logic [IW-1:0]   grant_q, grant_d;
    logic [IW-1:0]   last_q, last_d;
    logic [IW-1:0]   pick_idx;
    logic            pick_valid;
    logic            timeout_hit;
    logic            g_wr, g_rd;

    logic [ADDR_WIDTH-1:0] addr_a  [NUM_CORES];
    logic [DATA_WIDTH-1:0] wdata_a [NUM_CORES];

    for (genvar i = 0; i < NUM_CORES; i++) begin : g_unpack
        assign addr_a[i]  = req_address[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdata_a[i] = req_writedata[i*DATA_WIDTH +: DATA_WIDTH];
    end

    fprint_rr_picker #(
        .NUM_CORES (NUM_CORES),
        .IDX_W     (IW)
    ) u_picker (
        .req_i   (req_write | req_read),
        .last_i  (last_q),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB_STATE_IDLE;
            grant_q <= '0;
            last_q  <= IW'(NUM_CORES - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        grant_d          = grant_q;
        last_d           = last_q;
        master_write     = 1'b0;
        master_read      = 1'b0;
        master_address   = '0;
        master_writedata = '0;
        req_waitrequest  = '1;
        req_readdata     = '0;
        g_wr             = 1'b0;
        g_rd             = 1'b0;
        case (state_q)
            ARB_STATE_IDLE: begin
                if (pick_valid) begin
                    grant_d = pick_idx;
                    last_d  = pick_idx;
                    state_d = ARB_STATE_BUSY;
                end
            end
            ARB_STATE_BUSY: begin
                // Write wins when a core drives both strobes.
                g_wr                     = req_write[grant_q];
                g_rd                     = req_read[grant_q] & ~req_write[grant_q];
                master_write             = g_wr;
                master_read              = g_rd;
                master_address           = addr_a[grant_q];
                master_writedata         = wdata_a[grant_q];
                req_readdata             = master_readdata;
                req_waitrequest[grant_q] = master_waitrequest;
                if (timeout_hit) begin
                    master_write             = 1'b0;
                    master_read              = 1'b0;
                    req_waitrequest[grant_q] = 1'b0;
                    state_d                  = ARB_STATE_IDLE;
                end else if (!(g_wr || g_rd) || !master_waitrequest) begin
                    state_d = ARB_STATE_IDLE;
                end
            end
            default: state_d = ARB_STATE_IDLE;
        endcase
    end

`ifdef FPRINT_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_q, err_d;

    assign timeout_hit = (state_q == ARB_STATE_BUSY) && (tmo_q == TW'(TIMEOUT));

    // Counter sits at zero outside BUSY, so every grant starts a fresh stall count.
    always_comb begin
        tmo_d = tmo_q;
        err_d = err_q;
        if (state_q != ARB_STATE_BUSY) begin
            tmo_d = '0;
        end else if (master_waitrequest && !timeout_hit) begin
            tmo_d = tmo_q + TW'(1);
        end
        if (timeout_hit) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end

    assign arb_error = err_q;
`else
    assign timeout_hit = 1'b0;
    assign arb_error   = 1'b0;
`endif

    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fprint_master_arbiter.sv
// Self-checking bench for fprint_master_arbiter; the watchdog test runs when FPRINT_ARB_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_fprint_master_arbiter;
    import fprint_master_arbiter_pkg::*;

    localparam int NC  = 3;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 16;
    localparam int EW  = 4 + AW + DW;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NC*AW-1:0]     req_address;
    logic [NC-1:0]        req_write;
    logic [NC-1:0]        req_read;
    logic [NC*DW-1:0]     req_writedata;
    logic [NC-1:0]        req_waitrequest;
    logic [DW-1:0]        req_readdata;
    logic [AW-1:0]        master_address;
    logic                 master_write;
    logic                 master_read;
    logic [DW-1:0]        master_writedata;
    logic                 master_waitrequest;
    logic [DW-1:0]        master_readdata;
    logic                 arb_error;
    arb_state_e           dbg_state;

    fprint_master_arbiter #(
        .NUM_CORES  (NC),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .TIMEOUT    (TMO)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .req_address        (req_address),
        .req_write          (req_write),
        .req_read           (req_read),
        .req_writedata      (req_writedata),
        .req_waitrequest    (req_waitrequest),
        .req_readdata       (req_readdata),
        .master_address     (master_address),
        .master_write       (master_write),
        .master_read        (master_read),
        .master_writedata   (master_writedata),
        .master_waitrequest (master_waitrequest),
        .master_readdata    (master_readdata),
        .arb_error          (arb_error),
        .dbg_state_o        (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- core models ----------------
    logic          c_wr   [NC];
    logic          c_rd   [NC];
    logic [AW-1:0] c_addr [NC];
    logic [DW-1:0] c_data [NC];
    int            c_rem  [NC];

    always_comb begin
        req_write     = '0;
        req_read      = '0;
        req_address   = '0;
        req_writedata = '0;
        for (int i = 0; i < NC; i++) begin
            req_write[i]               = c_wr[i];
            req_read[i]                = c_rd[i];
            req_address[i*AW +: AW]    = c_addr[i];
            req_writedata[i*DW +: DW]  = c_data[i];
        end
    end

    // ---------------- slave model ----------------
    int  stall_cfg;
    int  stall_left;
    bit  busy_seen;

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    int            n_checks;
    int            n_errors;
    arb_state_e    s_state;
    logic          s_mw, s_mr, s_err;
    logic [NC-1:0] s_wait;
    logic [NC-1:0] done;
    logic [EW-1:0] obs;
    int            gcore;

    task automatic chk(input string tag, input logic [EW-1:0] got, input logic [EW-1:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    task automatic push(input int core, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_q.push_back({3'(core), wr, a, d});
    endtask

    task automatic issue(input int core, input logic wr, input logic rd,
                         input logic [AW-1:0] a, input logic [DW-1:0] d, input int cnt);
        c_wr[core]   = wr;
        c_rd[core]   = rd;
        c_addr[core] = a;
        c_data[core] = d;
        c_rem[core]  = cnt;
    endtask

    task automatic clear_cores();
        for (int i = 0; i < NC; i++) begin
            c_wr[i] = 1'b0; c_rd[i] = 1'b0; c_addr[i] = '0; c_data[i] = '0; c_rem[i] = 0;
        end
    endtask

    // One clock: sample/score at negedge, then update cores and slave after the rising edge.
    task automatic step();
        @(negedge clk);
        s_state = dbg_state;
        s_mw    = master_write;
        s_mr    = master_read;
        s_wait  = req_waitrequest;
        s_err   = arb_error;
        chk("one_grant", EW'($countones(~req_waitrequest) <= 1), EW'(1));
        done = '0;
        for (int i = 0; i < NC; i++)
            if ((c_wr[i] || c_rd[i]) && !req_waitrequest[i]) done[i] = 1'b1;
        if ((master_write || master_read) && !master_waitrequest) begin
            gcore = 0;
            for (int i = 0; i < NC; i++) if (!req_waitrequest[i]) gcore = i;
            obs = {3'(gcore), master_write, master_address, master_write ? master_writedata : req_readdata};
            if (exp_q.size() == 0) chk("exp_q_nonempty", EW'(exp_q.size()), EW'(1));
            else chk("xfer", obs, exp_q.pop_front());
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NC; i++) begin
            if (done[i]) begin
                c_rem[i]--;
                if (c_rem[i] <= 0) begin
                    c_wr[i] = 1'b0;
                    c_rd[i] = 1'b0;
                end else begin
                    c_addr[i] = c_addr[i] + 32'd4;
                    c_data[i] = c_data[i] + 32'd1;
                end
            end
        end
        #1;
        if (master_write || master_read) begin
            if (!busy_seen) begin
                stall_left = stall_cfg;
                busy_seen  = 1'b1;
            end
            master_waitrequest = (stall_left != 0);
            if (stall_left != 0) stall_left--;
        end else begin
            busy_seen          = 1'b0;
            master_waitrequest = 1'b0;
        end
    endtask

    task automatic drain(input int max_cycles);
        int pending;
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < max_cycles && !ok; n++) begin
            step();
            pending = exp_q.size();
            for (int i = 0; i < NC; i++) if (c_wr[i] || c_rd[i]) pending++;
            if (pending == 0) ok = 1'b1;
        end
        if (!ok) begin
            pending = exp_q.size();
            for (int i = 0; i < NC; i++) if (c_wr[i] || c_rd[i]) pending++;
            chk("drain_done", EW'(pending), EW'(0));
            exp_q.delete();
            clear_cores();
        end
        step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        n_checks = 0;
        n_errors = 0;
        clear_cores();
        stall_cfg          = 0;
        stall_left         = 0;
        busy_seen          = 1'b0;
        master_waitrequest = 1'b0;
        master_readdata    = '0;
        rst_n              = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mw",    EW'(master_write), EW'(0));
        chk("rst_mr",    EW'(master_read), EW'(0));
        chk("rst_addr",  EW'(master_address), EW'(0));
        chk("rst_wdata", EW'(master_writedata), EW'(0));
        chk("rst_wait",  EW'(req_waitrequest), EW'({NC{1'b1}}));
        chk("rst_err",   EW'(arb_error), EW'(0));
        chk("rst_state", EW'(dbg_state), EW'(ARB_STATE_IDLE));
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Single write, one-cycle latency, completion on first BUSY cycle.
        issue(0, 1'b1, 1'b0, 32'h0040_0040, 32'hDEAD_BEEF, 1);
        push(0, 1'b1, 32'h0040_0040, 32'hDEAD_BEEF);
        step();
        chk("sw_latency_mw", EW'(s_mw), EW'(0));
        step();
        chk("sw_cyc1_mw",    EW'(s_mw), EW'(1));
        chk("sw_cyc1_wait0", EW'(s_wait[0]), EW'(0));
        step();
        chk("sw_cyc2_idle",  EW'(s_state), EW'(ARB_STATE_IDLE));
        drain(10);

        // Contention from reset: strict alternation 0,1,0,1.
        do_reset();
        issue(0, 1'b1, 1'b0, 32'h0000_1000, 32'hA000_0000, 2);
        issue(1, 1'b1, 1'b0, 32'h0000_2000, 32'hB000_0000, 2);
        push(0, 1'b1, 32'h0000_1000, 32'hA000_0000);
        push(1, 1'b1, 32'h0000_2000, 32'hB000_0000);
        push(0, 1'b1, 32'h0000_1004, 32'hA000_0001);
        push(1, 1'b1, 32'h0000_2004, 32'hB000_0001);
        drain(40);

        // Downstream stall of 5 cycles, completion on BUSY cycle 6.
        stall_cfg = 5;
        issue(2, 1'b1, 1'b0, 32'h0000_3000, 32'h5555_AAAA, 1);
        push(2, 1'b1, 32'h0000_3000, 32'h5555_AAAA);
        step();
        for (int k = 0; k < 5; k++) begin
            step();
            chk("stall_wait_hi", EW'(s_wait[2]), EW'(1));
            chk("stall_mw_held", EW'(s_mw), EW'(1));
        end
        step();
        chk("stall_done_wait", EW'(s_wait[2]), EW'(0));
        stall_cfg = 0;
        drain(10);

        // Read path.
        master_readdata = 32'h1234_5678;
        issue(1, 1'b0, 1'b1, 32'h0000_0100, 32'h0, 1);
        push(1, 1'b0, 32'h0000_0100, 32'h1234_5678);
        drain(10);

        // Write and read together: counts as write, read suppressed.
        issue(0, 1'b1, 1'b1, 32'h0000_0200, 32'h0BAD_F00D, 1);
        push(0, 1'b1, 32'h0000_0200, 32'h0BAD_F00D);
        step();
        step();
        chk("both_mr_low", EW'(s_mr), EW'(0));
        drain(10);

        // Abort: granted core drops its request mid-stall; last still moves to core 0.
        stall_cfg = 10;
        issue(0, 1'b1, 1'b0, 32'h0000_0300, 32'h0, 1);
        step();
        step();
        chk("abort_busy_mw", EW'(s_mw), EW'(1));
        c_wr[0] = 1'b0;
        step();
        chk("abort_mw_drop", EW'(s_mw), EW'(0));
        step();
        chk("abort_idle", EW'(s_state), EW'(ARB_STATE_IDLE));
        stall_cfg = 0;
        issue(0, 1'b1, 1'b0, 32'h0000_0400, 32'h0000_0040, 1);
        issue(1, 1'b1, 1'b0, 32'h0000_0500, 32'h0000_0050, 1);
        push(1, 1'b1, 32'h0000_0500, 32'h0000_0050);
        push(0, 1'b1, 32'h0000_0400, 32'h0000_0040);
        drain(20);

        // Reset while stalled in BUSY.
        stall_cfg = 50;
        issue(2, 1'b1, 1'b0, 32'h0000_0600, 32'h0000_0060, 1);
        step();
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk("rstbusy_mw",   EW'(master_write), EW'(0));
        chk("rstbusy_wait", EW'(req_waitrequest), EW'({NC{1'b1}}));
        clear_cores();
        stall_cfg = 0;
        issue(1, 1'b1, 1'b0, 32'h0000_0700, 32'h0000_0071, 1);
        issue(0, 1'b1, 1'b0, 32'h0000_0800, 32'h0000_0080, 1);
        push(0, 1'b1, 32'h0000_0800, 32'h0000_0080);
        push(1, 1'b1, 32'h0000_0700, 32'h0000_0071);
        step();
        rst_n = 1'b1;
        step();
        chk("release_idle", EW'(s_state), EW'(ARB_STATE_IDLE));
        chk("release_mw",   EW'(s_mw), EW'(0));
        drain(20);

`ifdef FPRINT_ARB_TIMEOUT_EN
        // Watchdog: 16 stall cycles, then a one-cycle release pulse and sticky error.
        stall_cfg = 1000;
        issue(0, 1'b1, 1'b0, 32'h0000_0900, 32'h0000_0090, 1);
        step();
        for (int k = 0; k < TMO; k++) begin
            step();
            chk("tmo_stall_wait", EW'(s_wait[0]), EW'(1));
        end
        step();
        chk("tmo_pulse_wait", EW'(s_wait[0]), EW'(0));
        chk("tmo_pulse_mw",   EW'(s_mw), EW'(0));
        step();
        chk("tmo_err",  EW'(s_err), EW'(1));
        chk("tmo_idle", EW'(s_state), EW'(ARB_STATE_IDLE));
        stall_cfg = 0;
        issue(1, 1'b1, 1'b0, 32'h0000_0A00, 32'h0000_00A0, 1);
        push(1, 1'b1, 32'h0000_0A00, 32'h0000_00A0);
        drain(20);
        chk("tmo_err_sticky", EW'(arb_error), EW'(1));
`else
        chk("err_tied_low", EW'(arb_error), EW'(0));
`endif

        // Random single-requester traffic with random stalls.
        for (int t = 0; t < 24; t++) begin
            int            core;
            logic          wr;
            logic [AW-1:0] a;
            logic [DW-1:0] d;
            core            = $urandom_range(0, NC - 1);
            wr              = 1'($urandom_range(0, 1));
            a               = $urandom;
            d               = $urandom;
            stall_cfg       = $urandom_range(0, 3);
            master_readdata = $urandom;
            issue(core, wr, ~wr, a, d, 1);
            push(core, wr, a, wr ? d : master_readdata);
            drain(20);
        end

        chk("final_queue_empty", EW'(exp_q.size()), EW'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got time %0t required finish before it", $time);
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/fprint_master_arbiter.md
Name: fprint_master_arbiter

Overview:
- Shares one Avalon-MM master port, the path to the comparator, between NUM_CORES fingerprint-unit store-buffer masters.
- Round-robin arbitration. The grant is held until the granted transfer completes (downstream waitrequest low).
- Sits between the per-core fingerprint units and the system interconnect, so only one comparator port is needed per system.

Parameters:
- NUM_CORES, 2, number of requesting fingerprint units (2..8).
- ADDR_WIDTH, 32, Avalon address width (equals NIOS address width).
- DATA_WIDTH, 32, Avalon data width (equals NIOS data width).
- TIMEOUT, 1024, watchdog limit in cycles; used only with FPRINT_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous reset, active-low.
- req_address  in  NUM_CORES*ADDR_WIDTH  per-core address; core i occupies slice i.
- req_write  in  NUM_CORES  per-core write request.
- req_read  in  NUM_CORES  per-core read request.
- req_writedata  in  NUM_CORES*DATA_WIDTH  per-core write data.
- req_waitrequest  out  NUM_CORES  per-core waitrequest.
- req_readdata  out  DATA_WIDTH  shared read data, valid to the granted core only.
- master_address  out  ADDR_WIDTH  downstream address.
- master_write  out  1  downstream write.
- master_read  out  1  downstream read.
- master_writedata  out  DATA_WIDTH  downstream write data.
- master_waitrequest  in  1  downstream waitrequest.
- master_readdata  in  DATA_WIDTH  downstream read data.
- arb_error  out  1  sticky timeout flag; held 0 when the feature is compiled out.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, grant=0, last=NUM_CORES-1.
  - req_waitrequest=all 1s.
  - master_write=0, master_read=0, master_address=0, master_writedata=0.
  - arb_error=0.
- A core requests when req_write[i] or req_read[i] is 1. A core asserting both counts as a write; read is suppressed.
- State IDLE:
  - Downstream outputs are 0.
  - If any core requests, pick the first requesting index scanning last+1, last+2, … modulo NUM_CORES.
  - Register grant=index, last=index, and go to BUSY.
  - Request-to-downstream latency is 1 cycle.
- State BUSY:
  - Downstream signals are combinational copies of core[grant]'s signals.
  - req_waitrequest[grant]=master_waitrequest; every other core's waitrequest is 1.
  - req_readdata=master_readdata.
- Completion: in BUSY with master_waitrequest=0, the transfer completes that cycle and the next state is IDLE.
  - Minimum 2 cycles per transfer.
  - Back-to-back requests from different cores alternate strictly.
- Abort: if in BUSY the granted core drops both write and read (protocol violation), the downstream request deasserts combinationally and the next state is IDLE. last is still updated.
- Every non-granted core sees waitrequest=1 in all cycles and must hold its signals per Avalon rules.
- No transfer ever starts in the same cycle reset deasserts.
- Reset asserted mid-BUSY drops the downstream request immediately.
- Single-requester case: that core is re-granted every 2 cycles; no starvation by construction.

Optional Feature:
- Macro FPRINT_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to BUSY and increments each BUSY cycle with master_waitrequest=1.
  - On reaching TIMEOUT: force IDLE, deassert the downstream request, and pulse req_waitrequest[grant]=0 for one cycle so the core unblocks.
  - Set arb_error=1, which stays set until reset.
- Not defined: no counter; arb_error tied to 0; BUSY waits indefinitely.

Decomposition:
- Shared package/defines file (alongside the existing crc defines):
  - ARB_STATE_IDLE / ARB_STATE_BUSY encodings.
  - Default widths for ADDR_WIDTH and DATA_WIDTH.
  - Default TIMEOUT value.
- One natural sub-module: fprint_rr_picker, a combinational round-robin priority encoder. Inputs: request vector and last grant. Outputs: next index and a valid flag.

Test Plan:
- Single write: core0 writes addr 0x00400040, data 0xDEADBEEF, master_waitrequest low → master_write high on cycle 1 with that addr/data; req_waitrequest[0] low on cycle 1; IDLE on cycle 2.
- Contention: cores 0 and 1 request together after reset with last=1 → grant order 0, 1, 0, 1 across four transfers; the loser's waitrequest stays 1 throughout.
- Downstream stall: master_waitrequest high for 5 cycles → core signals held, req_waitrequest[grant]=1 for 5 cycles, completion on cycle 6 of BUSY.
- Read path: core1 reads with master_readdata=0x12345678 → req_readdata=0x12345678 in the completion cycle, req_waitrequest[1]=0.
- Reset in BUSY: rst_n low during a stall → master_write=0 immediately and all req_waitrequest=1; after release, first grant goes to core0.
- With FPRINT_ARB_TIMEOUT_EN and TIMEOUT=16: waitrequest stuck high → after 16 stall cycles arb_error=1, one-cycle req_waitrequest[grant]=0, state returns to IDLE; other cores are served afterwards.
